// File: rtl/riscv_core_arb_pkg.sv
// rtl/riscv_core_arb_pkg.sv - shared types for the IF/LS memory port arbiter
package riscv_core_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_ADDR = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWNER_IF = 1'b0,
        OWNER_LS = 1'b1
    } arb_owner_t;

endpackage

// File: rtl/riscv_core_arb_pick.sv
// rtl/riscv_core_arb_pick.sv - combinational round-robin / lock picker
//
// Ports:
//   i_if_req, i_ls_req  requests from instruction fetch and load/store
//   i_last_owner        port that received the most recent grant (0 = IF, 1 = LS)
//   i_lock              bus held for LS; IF request is ignored while set
//   o_pick              chosen port (0 = IF, 1 = LS)
module riscv_core_arb_pick
    import riscv_core_arb_pkg::*;
(
    input  logic i_if_req,
    input  logic i_ls_req,
    input  logic i_last_owner,
    input  logic i_lock,
    output logic o_pick
);

    always_comb begin
        o_pick = OWNER_IF;
        if (i_lock) begin
            o_pick = OWNER_LS;
        end else if (i_if_req && i_ls_req) begin
            // Tie: whoever did not win last time goes now.
            o_pick = ~i_last_owner;
        end else if (i_ls_req) begin
            o_pick = OWNER_LS;
        end
    end

endmodule

// File: rtl/riscv_core_mem_arbiter.sv
// rtl/riscv_core_mem_arbiter.sv - shares one memory port between IF (port 0) and LS (port 1)
//
// Optional feature macro: RISCV_CORE_ARB_LOCK_EN (adds i_ls_lock and bus locking for LS).
//
// Ports:
//   i_clk, i_rst_n                     clock, synchronous active-low reset
//   i_if_req/i_if_addr, o_if_gnt       IF address phase (read only)
//   o_if_rvalid/o_if_rdata             IF response
//   i_ls_req/addr/we/wdata/be, o_ls_gnt LS address phase
//   i_ls_lock                          keep bus for next LS access (lock build only)
//   o_ls_rvalid/o_ls_rdata             LS response
//   o_mem_req/addr/we/wdata/be         muxed bus request
//   i_mem_gnt, i_mem_rvalid/rdata      bus handshake and response
//   o_owner                            path select: 0 = IF, 1 = LS
module riscv_core_mem_arbiter
    import riscv_core_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_if_req,
    input  logic [ADDR_WIDTH-1:0]   i_if_addr,
    output logic                    o_if_gnt,
    output logic                    o_if_rvalid,
    output logic [DATA_WIDTH-1:0]   o_if_rdata,
    input  logic                    i_ls_req,
    input  logic [ADDR_WIDTH-1:0]   i_ls_addr,
    input  logic                    i_ls_we,
    input  logic [DATA_WIDTH-1:0]   i_ls_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_ls_be,
`ifdef RISCV_CORE_ARB_LOCK_EN
    input  logic                    i_ls_lock,
`endif
    output logic                    o_ls_gnt,
    output logic                    o_ls_rvalid,
    output logic [DATA_WIDTH-1:0]   o_ls_rdata,
    output logic                    o_mem_req,
    output logic [ADDR_WIDTH-1:0]   o_mem_addr,
    output logic                    o_mem_we,
    output logic [DATA_WIDTH-1:0]   o_mem_wdata,
    output logic [DATA_WIDTH/8-1:0] o_mem_be,
    input  logic                    i_mem_gnt,
    input  logic                    i_mem_rvalid,
    input  logic [DATA_WIDTH-1:0]   i_mem_rdata,
    output logic                    o_owner
);

    localparam int BE_W = DATA_WIDTH / 8;

    arb_state_t state_q, state_d;
    logic       owner_q, owner_d;
    logic       last_owner_q, last_owner_d;
    logic       lock_act;

`ifdef RISCV_CORE_ARB_LOCK_EN
    logic       lock_q, lock_d;
    assign lock_act = lock_q;
`else
    assign lock_act = 1'b0;
`endif

    logic if_req_eff;
    logic pick;
    logic owner_sel;
    logic mem_req_raw;

    // A locked bus hides IF entirely, including from o_mem_req.
    assign if_req_eff = i_if_req & ~lock_act;

    riscv_core_arb_pick u_pick (
        .i_if_req     (if_req_eff),
        .i_ls_req     (i_ls_req),
        .i_last_owner (last_owner_q),
        .i_lock       (lock_act),
        .o_pick       (pick)
    );

    // In IDLE the picker drives the path directly so a same-cycle bus
    // grant costs no arbitration cycle; afterwards the owner is frozen.
    always_comb begin
        owner_sel   = owner_q;
        mem_req_raw = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                owner_sel   = pick;
                mem_req_raw = if_req_eff | i_ls_req;
            end
            ARB_ADDR: mem_req_raw = 1'b1;
            default:  mem_req_raw = 1'b0;
        endcase
    end

    assign o_owner   = i_rst_n & owner_sel;
    assign o_mem_req = i_rst_n & mem_req_raw;
    assign o_if_gnt  = o_mem_req & i_mem_gnt & (o_owner == OWNER_IF);
    assign o_ls_gnt  = o_mem_req & i_mem_gnt & (o_owner == OWNER_LS);

    assign o_if_rvalid = i_rst_n & (state_q == ARB_RESP) & i_mem_rvalid & (owner_q == OWNER_IF);
    assign o_ls_rvalid = i_rst_n & (state_q == ARB_RESP) & i_mem_rvalid & (owner_q == OWNER_LS);
    assign o_if_rdata  = i_mem_rdata;
    assign o_ls_rdata  = i_mem_rdata;

    assign o_mem_addr  = (o_owner == OWNER_LS) ? i_ls_addr  : i_if_addr;
    assign o_mem_we    = (o_owner == OWNER_LS) ? i_ls_we    : 1'b0;
    assign o_mem_wdata = (o_owner == OWNER_LS) ? i_ls_wdata : '0;
    assign o_mem_be    = (o_owner == OWNER_LS) ? i_ls_be    : {BE_W{1'b1}};

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        case (state_q)
            ARB_IDLE: begin
                if (mem_req_raw) begin
                    owner_d = pick;
                    if (i_mem_gnt) begin
                        last_owner_d = pick;
                        state_d      = ARB_RESP;
                    end else begin
                        state_d = ARB_ADDR;
                    end
                end
            end
            ARB_ADDR: begin
                if (i_mem_gnt) begin
                    last_owner_d = owner_q;
                    state_d      = ARB_RESP;
                end
            end
            ARB_RESP: begin
                if (i_mem_rvalid) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

`ifdef RISCV_CORE_ARB_LOCK_EN
    always_comb begin
        lock_d = lock_q;
        if (o_ls_gnt) begin
            lock_d = i_ls_lock;
        end
    end
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q      <= ARB_IDLE;
            owner_q      <= OWNER_IF;
            last_owner_q <= OWNER_IF;
`ifdef RISCV_CORE_ARB_LOCK_EN
            lock_q       <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
`ifdef RISCV_CORE_ARB_LOCK_EN
            lock_q       <= lock_d;
`endif
        end
    end

    // The frozen owner must keep requesting until the bus accepts it.
    a_req_held_in_addr: assert property (
        @(posedge i_clk) disable iff (!i_rst_n)
        (state_q == ARB_ADDR) |-> ((owner_q == OWNER_LS) ? i_ls_req : i_if_req)
    );

endmodule

// File: tb/tb_riscv_core_mem_arbiter.sv
// tb/tb_riscv_core_mem_arbiter.sv - directed and random self-checking bench for the memory arbiter
module tb_riscv_core_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [63:0] if_addr;
    logic        if_gnt, if_rvalid;
    logic [63:0] if_rdata;
    logic        ls_req;
    logic [63:0] ls_addr;
    logic        ls_we;
    logic [63:0] ls_wdata;
    logic [7:0]  ls_be;
    logic        ls_lock;
    logic        ls_gnt, ls_rvalid;
    logic [63:0] ls_rdata;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic        mem_we;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_be;
    logic        mem_gnt, mem_rvalid;
    logic [63:0] mem_rdata;
    logic        owner;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    riscv_core_mem_arbiter #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_if_req     (if_req),
        .i_if_addr    (if_addr),
        .o_if_gnt     (if_gnt),
        .o_if_rvalid  (if_rvalid),
        .o_if_rdata   (if_rdata),
        .i_ls_req     (ls_req),
        .i_ls_addr    (ls_addr),
        .i_ls_we      (ls_we),
        .i_ls_wdata   (ls_wdata),
        .i_ls_be      (ls_be),
`ifdef RISCV_CORE_ARB_LOCK_EN
        .i_ls_lock    (ls_lock),
`endif
        .o_ls_gnt     (ls_gnt),
        .o_ls_rvalid  (ls_rvalid),
        .o_ls_rdata   (ls_rdata),
        .o_mem_req    (mem_req),
        .o_mem_addr   (mem_addr),
        .o_mem_we     (mem_we),
        .o_mem_wdata  (mem_wdata),
        .o_mem_be     (mem_be),
        .i_mem_gnt    (mem_gnt),
        .i_mem_rvalid (mem_rvalid),
        .i_mem_rdata  (mem_rdata),
        .o_owner      (owner)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic quiet();
        if_req = 0; ls_req = 0; mem_gnt = 0; mem_rvalid = 0; ls_lock = 0;
    endtask

    task automatic do_reset();
        quiet();
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
        tick();
    endtask

    // Random-phase monitor state
    bit g_if = 0, g_ls = 0;
    bit in_resp = 0, last_ls = 0;
    int cnt_gnt_if = 0, cnt_gnt_ls = 0, cnt_rv_if = 0, cnt_rv_ls = 0;

    task automatic rnd_cycle(input bit drain);
        if (g_if) if_req = 0;
        if (g_ls) ls_req = 0;
        if (!drain) begin
            if (!if_req && $urandom_range(0, 3) == 0) begin
                if_req  = 1;
                if_addr = {32'h0, $urandom};
            end
            if (!ls_req && $urandom_range(0, 3) == 0) begin
                ls_req   = 1;
                ls_addr  = {32'h1, $urandom};
                ls_we    = 1'($urandom_range(0, 1));
                ls_wdata = {$urandom, $urandom};
                ls_be    = 8'($urandom);
            end
        end
        mem_gnt    = drain ? 1'b1 : 1'($urandom_range(0, 1));
        mem_rvalid = drain ? in_resp : ($urandom_range(0, 2) == 0);
        mem_rdata  = {$urandom, $urandom};
        mid();
        g_if = if_gnt;
        g_ls = ls_gnt;
        if (in_resp) chk("rnd_gnt_in_resp", {g_if, g_ls}, 0);
        chk("rnd_two_gnt", g_if & g_ls, 0);
        chk("rnd_if_rvalid", if_rvalid, in_resp & mem_rvalid & ~last_ls);
        chk("rnd_ls_rvalid", ls_rvalid, in_resp & mem_rvalid & last_ls);
        chk("rnd_ls_rdata", ls_rdata, mem_rdata);
        cnt_rv_if  += int'(if_rvalid);
        cnt_rv_ls  += int'(ls_rvalid);
        cnt_gnt_if += int'(g_if);
        cnt_gnt_ls += int'(g_ls);
        if (in_resp && mem_rvalid) begin
            in_resp = 0;
        end else if (g_if || g_ls) begin
            in_resp = 1;
            last_ls = g_ls;
        end
        tick();
    endtask

    initial begin
        bit exp_ls;
        bit done;
        if_addr = 0; ls_addr = 0; ls_we = 0; ls_wdata = 0; ls_be = 0; mem_rdata = 0;
        quiet();
        rst_n = 0;
        tick();

        // Reset: handshake outputs forced low even with activity on the inputs
        if_req = 1; ls_req = 1; mem_gnt = 1; mem_rvalid = 1;
        mid();
        chk("rst_mem_req", mem_req, 0);
        chk("rst_gnts", {if_gnt, ls_gnt}, 0);
        chk("rst_rvalids", {if_rvalid, ls_rvalid}, 0);
        chk("rst_owner", owner, 0);
        tick();
        quiet();
        rst_n = 1;
        tick();

        // 1: single IF fetch
        if_req = 1; if_addr = 64'h1000; mem_gnt = 1;
        mid();
        chk("t1_if_gnt", if_gnt, 1);
        chk("t1_ls_gnt", ls_gnt, 0);
        chk("t1_owner", owner, 0);
        chk("t1_addr", mem_addr, 64'h1000);
        chk("t1_we_be", {mem_we, mem_be}, {1'b0, 8'hFF});
        chk("t1_wdata", mem_wdata, 0);
        tick();
        if_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 64'hA5;
        mid();
        chk("t1_if_rvalid", if_rvalid, 1);
        chk("t1_if_rdata", if_rdata, 64'hA5);
        chk("t1_ls_rvalid", ls_rvalid, 0);
        chk("t1_resp_req", mem_req, 0);
        tick();
        mem_rvalid = 0;

        // 2: contention alternates, LS first after reset
        do_reset();
        ls_addr = 64'h3000; ls_we = 0; ls_be = 8'hFF; if_addr = 64'h1100;
        exp_ls = 1;
        for (int r = 0; r < 8; r++) begin
            if_req = 1; ls_req = 1; mem_gnt = 1; mem_rvalid = 0;
            mid();
            chk("t2_if_gnt", if_gnt, !exp_ls);
            chk("t2_ls_gnt", ls_gnt, exp_ls);
            chk("t2_owner", owner, exp_ls);
            tick();
            mem_gnt = 0; mem_rvalid = 1; mem_rdata = 64'(r);
            mid();
            chk("t2_bubble_req", mem_req, 0);
            chk("t2_if_rvalid", if_rvalid, !exp_ls);
            chk("t2_ls_rvalid", ls_rvalid, exp_ls);
            tick();
            exp_ls = !exp_ls;
        end
        quiet();

        // 3: LS store stalled by the bus for three cycles
        ls_req = 1; ls_addr = 64'h2000; ls_we = 1; ls_be = 8'h0F; ls_wdata = 64'hDEAD;
        for (int c = 1; c <= 4; c++) begin
            mem_gnt = (c == 4);
            mid();
            chk("t3_req", mem_req, 1);
            chk("t3_addr", mem_addr, 64'h2000);
            chk("t3_we_be", {mem_we, mem_be}, {1'b1, 8'h0F});
            chk("t3_wdata", mem_wdata, 64'hDEAD);
            chk("t3_ls_gnt", ls_gnt, (c == 4));
            chk("t3_if_gnt", if_gnt, 0);
            tick();
        end
        ls_req = 0; mem_gnt = 0; mem_rvalid = 1;
        mid();
        chk("t3_resp_req", mem_req, 0);
        chk("t3_ls_rvalid", ls_rvalid, 1);
        tick();
        quiet();

        // 4: reset while a response is outstanding
        if_req = 1; if_addr = 64'h1200; mem_gnt = 1;
        mid();
        chk("t4_if_gnt", if_gnt, 1);
        tick();
        if_req = 0; mem_gnt = 0; rst_n = 0; mem_rvalid = 1;
        mid();
        chk("t4_rst_rvalids", {if_rvalid, ls_rvalid}, 0);
        chk("t4_rst_req_gnt", {mem_req, if_gnt, ls_gnt}, 0);
        tick();
        rst_n = 1;
        mid();
        chk("t4_late_rvalids", {if_rvalid, ls_rvalid}, 0);
        chk("t4_late_req", mem_req, 0);
        tick();
        mem_rvalid = 0; if_req = 1; mem_gnt = 1;
        mid();
        chk("t4_idle_gnt", if_gnt, 1);
        tick();
        if_req = 0; mem_gnt = 0; mem_rvalid = 1;
        mid();
        chk("t4_post_rvalid", if_rvalid, 1);
        tick();
        quiet();

`ifdef RISCV_CORE_ARB_LOCK_EN
        // 5: locked LS sequence holds off a pending IF
        do_reset();
        for (int k = 0; k < 3; k++) begin
            if_req = 1; ls_req = (k < 2); ls_lock = (k == 0); mem_gnt = 1; mem_rvalid = 0;
            mid();
            chk("t5_ls_gnt", ls_gnt, (k < 2));
            chk("t5_if_gnt", if_gnt, (k == 2));
            tick();
            if_req = 0; ls_req = 0; mem_gnt = 0; mem_rvalid = 1;
            mid();
            chk("t5_rvalid", {if_rvalid, ls_rvalid}, (k < 2) ? 2'b01 : 2'b10);
            tick();
        end
        quiet();
`endif

        // 6: random traffic with protocol-correct requesters
        do_reset();
        for (int i = 0; i < 10000; i++) rnd_cycle(0);
        done = 0;
        for (int i = 0; i < 50; i++) begin
            if (!in_resp && !(if_req && !g_if) && !(ls_req && !g_ls)) begin
                done = 1;
                break;
            end
            rnd_cycle(1);
        end
        chk("rnd_drain_done", done, 1);
        chk("rnd_cnt_if", 64'(cnt_rv_if), 64'(cnt_gnt_if));
        chk("rnd_cnt_ls", 64'(cnt_rv_ls), 64'(cnt_gnt_ls));
        chk("rnd_activity", (cnt_gnt_if > 100) && (cnt_gnt_ls > 100), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
